exe_stage: RTL
==============

Name: exe_stage

Overview:
- Execute stage of the 16-bit SIMD AES pipeline.
- Consumes the 60-bit packed bundle from the ID/EXE register and runs the ALU on it. Most ops complete in one cycle. One op, GMUL, is a multi-cycle byte-lane GF(2^8) multiply.
- Registers the result into a 39-bit EXE/MEM bundle.
- Asserts stall upstream while GMUL iterates.

Parameters:
- DATA_W, 16, datapath width (two 8-bit SIMD lanes).
- GMUL_STEPS, 8, shift-add iterations per GMUL.

Ports:
- clock  in  1  clock; all state updates on posedge.
- reset_n  in  1  reset; synchronous, active-low.
- id_exe_in  in  60  bundle fields, MSB first:
  - inmediato[59:44]
  - sel_mux_alu[43]
  - destiny[42:39]
  - writeBack[38]
  - AluControl[37:34]
  - mem_wr[33]
  - mem_rd[32]
  - output_a[31:16]
  - output_b[15:0]
- in_valid  in  1  bundle holds a real instruction.
- flush  in  1  kill the in-flight instruction.
- stall  out  1  upstream must hold id_exe_in.
- exe_mem_out  out  39  fields, MSB first:
  - destiny[38:35]
  - writeBack[34]
  - mem_wr[33]
  - mem_rd[32]
  - alu_result[31:16]
  - store_data[15:0] (= output_b)
- out_valid  out  1  exe_mem_out holds a valid instruction.

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE, cnt=0, exe_mem_out=0, out_valid=0. stall=0 while reset_n=0.
- Operand B: opb = sel_mux_alu ? inmediato : output_b. opa = output_a.
- AluControl opcodes (16-bit, wrap modulo 2^16, no flags):
  - 0 ADD
  - 1 SUB (a-b)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SHL by opb[3:0]
  - 6 SHR (logical) by opb[3:0]
  - 7 SWAP: {a[7:0],a[15:8]}
  - 8 XTIME, per byte: (x<<1) ^ (x[7] ? 8'h1B : 0)
  - 9 GMUL, per byte: a_lane * b_lane mod x^8+x^4+x^3+x+1
  - A PASSB
  - B-F: result 0
- Single-cycle ops: in IDLE with in_valid=1, the next posedge loads exe_mem_out and sets out_valid=1. Latency 1 cycle.
- in_valid=0 in IDLE: bubble. out_valid=0; writeBack, mem_wr and mem_rd are forced 0 in exe_mem_out; other fields don't-care, driven 0.
- FSM states: IDLE, MUL.
  - IDLE -> MUL when in_valid and op=GMUL. Latches opa/opb lanes; acc=0; cnt=0; outputs a bubble.
  - MUL, each posedge, per lane:
    - if b[0]: acc ^= a
    - a = xtime(a)
    - b >>= 1
    - cnt++
  - On the step with cnt=GMUL_STEPS-1: write exe_mem_out with the final acc, out_valid=1, return to IDLE.
- stall (combinational) = in_valid & op==GMUL & ~(state==MUL & cnt==GMUL_STEPS-1).
  - High for 8 cycles; GMUL occupies 9 cycles.
  - The upstream bundle advances on the posedge where stall=0.
- Control fields (destiny, writeBack, mem_*) for GMUL come from id_exe_in at completion. Upstream holds them stable while stall=1.
- flush=1 at posedge: state->IDLE, cnt=0, out_valid=0, bubble written. Applies in any state and overrides the accept of a new instruction. stall is forced 0 while flush=1.
- in_valid drops while in MUL: abort to IDLE, emit bubble (defensive; upstream must not do this).
- reset_n=0 mid-GMUL: immediate return to reset values; no partial result escapes.

Decomposition:
- Package exe_pkg:
  - alu_op_e enum (codes above)
  - bundle field index localparams for both bundles
  - exe_state_e {IDLE, MUL}
  - AES_POLY = 8'h1B
  - xtime function
- Sub-module gf_mul_step: combinational single-lane step (acc, a, b -> acc', a', b'). Instantiated twice.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with in_valid=1 -> exe_mem_out=0, out_valid=0, stall=0.
- ADD a=0xFFFF, b=0x0002, sel_mux_alu=0, destiny=5, writeBack=1 -> next cycle alu_result=0x0001, destiny=5, writeBack=1, out_valid=1.
- ADD with sel_mux_alu=1, inmediato=0x0010, a=0x0020 -> alu_result=0x0030, store_data=output_b unchanged.
- XTIME a=0x8057 -> alu_result=0x1BAE.
- GMUL a=0x5757, b=0x8313 -> stall high exactly 8 cycles, then alu_result=0xC1FE, out_valid=1 on the 9th posedge. The following ADD completes on the next cycle.
- flush asserted at MUL cnt=3 -> next cycle out_valid=0, state IDLE, stall=0. Same stimulus with reset_n pulsed low instead -> all outputs 0.

Source files
------------

// File: rtl/exe_pkg.sv
// exe_pkg: shared types, bundle field positions and GF(2^8) helpers for the execute stage
package exe_pkg;
  localparam int DATA_W = 16;
  localparam int ID_W = 60;
  localparam int EX_W = 39;
  localparam int ID_IMM_LSB = 44;
  localparam int ID_SEL = 43;
  localparam int ID_DEST_LSB = 39;
  localparam int ID_WB = 38;
  localparam int ID_ALU_LSB = 34;
  localparam int ID_MWR = 33;
  localparam int ID_MRD = 32;
  localparam int ID_A_LSB = 16;
  localparam int ID_B_LSB = 0;
  localparam int EX_DEST_LSB = 35;
  localparam int EX_WB = 34;
  localparam int EX_MWR = 33;
  localparam int EX_MRD = 32;
  localparam int EX_RES_LSB = 16;
  localparam int EX_ST_LSB = 0;
  localparam logic [7:0] AES_POLY = 8'h1B;
  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR = 4'h3, OP_XOR = 4'h4, OP_SHL = 4'h5,
    OP_SHR = 4'h6, OP_SWAP = 4'h7, OP_XTIME = 4'h8, OP_GMUL = 4'h9, OP_PASSB = 4'hA
  } alu_op_e;
  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} exe_state_e;
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/exe_stage_gf_mul_step.sv
// gf_mul_step: one shift-add iteration of a single-lane GF(2^8) multiply
module gf_mul_step
  import exe_pkg::*;
(
  input  logic [7:0] acc_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] acc_o,
  output logic [7:0] a_o,
  output logic [7:0] b_o
);
  always_comb begin
    acc_o = b_i[0] ? acc_i ^ a_i : acc_i;
    a_o = xtime(a_i);
    b_o = {1'b0, b_i[7:1]};
  end
endmodule

// File: rtl/exe_stage.sv
// exe_stage: SIMD AES execute stage with single-cycle ALU and iterative byte-lane GMUL
module exe_stage
  import exe_pkg::*;
#(
  parameter int GMUL_STEPS = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [ID_W-1:0] id_exe_in,
  input  logic            in_valid,
  input  logic            flush,
  output logic            stall,
  output logic [EX_W-1:0] exe_mem_out,
  output logic            out_valid
);
  localparam int CNT_W = (GMUL_STEPS > 1) ? $clog2(GMUL_STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(GMUL_STEPS - 1);
  exe_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [DATA_W-1:0] a_n, b_n, acc_n;
  logic [EX_W-1:0] out_q, out_d;
  logic valid_q, valid_d;
  logic [DATA_W-1:0] opa, opb, store, alu_res;
  logic [6:0] ctrl;
  alu_op_e op;
  logic last;
  always_comb begin
    op = alu_op_e'(id_exe_in[ID_ALU_LSB +: 4]);
    opa = id_exe_in[ID_A_LSB +: DATA_W];
    store = id_exe_in[ID_B_LSB +: DATA_W];
    opb = id_exe_in[ID_SEL] ? id_exe_in[ID_IMM_LSB +: DATA_W] : store;
    ctrl = {id_exe_in[ID_DEST_LSB +: 4], id_exe_in[ID_WB], id_exe_in[ID_MWR], id_exe_in[ID_MRD]};
    last = (state_q == MUL) && (cnt_q == LAST);
    stall = reset_n & ~flush & in_valid & (op == OP_GMUL) & ~last;
  end
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:   alu_res = opa + opb;
      OP_SUB:   alu_res = opa - opb;
      OP_AND:   alu_res = opa & opb;
      OP_OR:    alu_res = opa | opb;
      OP_XOR:   alu_res = opa ^ opb;
      OP_SHL:   alu_res = opa << opb[3:0];
      OP_SHR:   alu_res = opa >> opb[3:0];
      OP_SWAP:  alu_res = {opa[7:0], opa[15:8]};
      OP_XTIME: alu_res = {xtime(opa[15:8]), xtime(opa[7:0])};
      OP_PASSB: alu_res = opb;
      default:  alu_res = '0;
    endcase
  end
  for (genvar g = 0; g < 2; g++) begin : g_lane
    gf_mul_step u_step (
      .acc_i(acc_q[g*8 +: 8]),
      .a_i  (a_q[g*8 +: 8]),
      .b_i  (b_q[g*8 +: 8]),
      .acc_o(acc_n[g*8 +: 8]),
      .a_o  (a_n[g*8 +: 8]),
      .b_o  (b_n[g*8 +: 8])
    );
  end
  // Every non-result path (flush, abort, GMUL start) leaves out_d as an all-zero bubble
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    out_d = '0;
    valid_d = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d = '0;
    end else if (state_q == IDLE) begin
      if (in_valid && op == OP_GMUL) begin
        state_d = MUL;
        cnt_d = '0;
        a_d = opa;
        b_d = opb;
        acc_d = '0;
      end else if (in_valid) begin
        out_d = {ctrl, alu_res, store};
        valid_d = 1'b1;
      end
    end else if (!in_valid) begin
      state_d = IDLE;
      cnt_d = '0;
    end else begin
      a_d = a_n;
      b_d = b_n;
      acc_d = acc_n;
      cnt_d = cnt_q + CNT_W'(1);
      if (last) begin
        state_d = IDLE;
        cnt_d = '0;
        out_d = {ctrl, acc_n, store};
        valid_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      out_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      out_q <= out_d;
      valid_q <= valid_d;
    end
  end
  assign exe_mem_out = out_q;
  assign out_valid = valid_q;
endmodule
